// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : shared widths, reset vectors, responder states and CPU opcodes
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 6;

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] RESET_SP = '1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } resp_state_e;

  // Opcode lives in the top nibble, operand address in the low bits
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_STA  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_JZ   = 4'h6;
  localparam logic [3:0] OP_PUSH = 4'h7;
  localparam logic [3:0] OP_POP  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  function automatic logic [DATA_WIDTH-1:0] asm_word(input logic [3:0] op,
                                                    input logic [ADDR_WIDTH-1:0] arg);
    return {op, {(DATA_WIDTH-4-ADDR_WIDTH){1'b0}}, arg};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// mem_array : single-port word store, synchronous write-first registered read
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic                  rd_zero,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] ram_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  // rd_zero forces the output register to 0 while the CPU is not released
  always_comb begin
    rdata_d = ram_q[addr];
    if (we)      rdata_d = wdata;
    if (rd_zero) rdata_d = '0;
  end

  always_ff @(posedge clk) begin
    if (we) ram_q[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// mem_responder : clears, loads a host program image, then serves the CPU bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int LOAD_BASE  = int'(cpu_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] mem,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  input  logic                  ld_boot,
  output logic                  ld_ready,
  output logic                  run
);

  import cpu_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] LD_BASE = ADDR_WIDTH'(LOAD_BASE);

  resp_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_WIDTH-1:0] ld_cnt_q, ld_cnt_d;

  logic [ADDR_WIDTH-1:0] arr_addr;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic                  arr_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  // Array port is owned by the clearer, then the loader, then the CPU
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    arr_addr  = addr;
    arr_wdata = data;
    arr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        arr_addr  = clr_cnt_q;
        arr_wdata = '0;
        arr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        arr_addr  = LD_BASE + ld_cnt_q;
        arr_wdata = ld_data;
        arr_we    = ld_valid;
        if (ld_valid) ld_cnt_d = ld_cnt_q + 1'b1;
        if ((ld_valid && ld_last) || ld_boot) state_d = ST_RUN;
      end
      ST_RUN: begin
        arr_we = we;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  assign ld_ready = (state_q == ST_LOAD);
  assign run      = (state_q == ST_RUN);

  mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (arr_addr),
    .wdata   (arr_wdata),
    .we      (arr_we),
    .rd_zero (state_q != ST_RUN),
    .rdata   (mem)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// tb_mem_responder : directed stimulus with a queued scoreboard for CPU reads
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_responder;

  localparam int DW = 16;
  localparam int AW = 6;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic [AW-1:0] addr     = '0;
  logic [DW-1:0] data     = '0;
  logic          we       = 1'b0;
  logic [DW-1:0] mem;
  logic          ld_valid = 1'b0;
  logic [DW-1:0] ld_data  = '0;
  logic          ld_last  = 1'b0;
  logic          ld_boot  = 1'b0;
  logic          ld_ready;
  logic          run;

  always #5 clk = ~clk;

  mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LOAD_BASE  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data     (data),
    .we       (we),
    .mem      (mem),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_boot  (ld_boot),
    .ld_ready (ld_ready),
    .run      (run)
  );

  typedef struct {
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic rd_req   = 1'b0;
  logic rd_due   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A read issued before edge N is due at the negedge after edge N
  always @(posedge clk) rd_due <= rd_req;

  always @(negedge clk) begin
    if (rd_due) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got mem 0x%0h, expected a queued entry", mem);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check(e.name, {16'h0, mem}, {16'h0, e.exp});
      end
    end
  end

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    addr   = a;
    we     = 1'b0;
    rd_req = 1'b1;
    sb_q.push_back('{exp, $sformatf("rd_addr%0d", a)});
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr   = a;
    data   = d;
    we     = 1'b1;
    rd_req = 1'b1;
    sb_q.push_back('{d, $sformatf("wr_first_addr%0d", a)});
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic cpu_idle();
    rd_req = 1'b0;
    we     = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_boot  = 1'b0;
    we       = 1'b0;
    rd_req   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at the negedge where reset is released; CLEAR spans 64 edges
  task automatic wait_clear(input bit full);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      check($sformatf("ld_ready_clr%0d", i), {31'h0, ld_ready}, {31'h0, (i == 64)});
      if (full) begin
        check($sformatf("run_clr%0d", i), {31'h0, run}, 32'h0);
        check($sformatf("mem_clr%0d", i), {16'h0, mem}, 32'h0);
      end
    end
  endtask

  task automatic load_word(input logic [DW-1:0] w, input logic last);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic boot_pulse();
    ld_boot = 1'b1;
    @(negedge clk);
    ld_boot = 1'b0;
    check("run_after_boot", {31'h0, run}, 32'h1);
    check("ld_ready_after_boot", {31'h0, ld_ready}, 32'h0);
  endtask

  initial begin
    #1;
    check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check("rst_run", {31'h0, run}, 32'h0);
    check("rst_mem", {16'h0, mem}, 32'h0);

    // Reset release, then a 3-word image with ld_last on the third word
    do_reset();
    wait_clear(1'b1);
    load_word(16'h1234, 1'b0);
    check("run_after_w1", {31'h0, run}, 32'h0);
    load_word(16'hABCD, 1'b0);
    check("run_after_w2", {31'h0, run}, 32'h0);
    load_word(16'hF000, 1'b1);
    check("run_after_last", {31'h0, run}, 32'h1);
    check("ld_ready_after_last", {31'h0, ld_ready}, 32'h0);
    check("mem_on_run_entry", {16'h0, mem}, 32'h0);
    ld_valid = 1'b1;
    ld_data  = 16'hDEAD;
    cpu_read(6'd8,  16'h1234);
    cpu_read(6'd9,  16'hABCD);
    cpu_read(6'd10, 16'hF000);
    cpu_read(6'd7,  16'h0000);
    ld_valid = 1'b0;
    cpu_read(6'd11, 16'h0000);

    // Write-first, then a plain read-back of the same address
    cpu_write(6'd20, 16'h5A5A);
    cpu_read(6'd20, 16'h5A5A);
    cpu_read(6'd8,  16'h1234);
    cpu_read(6'd20, 16'h5A5A);
    cpu_idle();
    check("mem_hold_run", {16'h0, mem}, 32'h5A5A);

    // Reset during RUN must clear outputs asynchronously
    rst_n = 1'b0;
    #1;
    check("async_rst_mem", {16'h0, mem}, 32'h0);
    check("async_rst_run", {31'h0, run}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b0);

    // 60 words from address 8: the last four wrap to addresses 0..3
    for (int i = 0; i < 60; i++) load_word(16'hC000 + 16'(i), (i == 59));
    check("run_after_60", {31'h0, run}, 32'h1);
    cpu_read(6'd0,  16'hC038);
    cpu_read(6'd1,  16'hC039);
    cpu_read(6'd2,  16'hC03A);
    cpu_read(6'd3,  16'hC03B);
    cpu_read(6'd4,  16'h0000);
    cpu_read(6'd8,  16'hC000);
    cpu_read(6'd63, 16'hC037);
    cpu_read(6'd20, 16'hC00C);
    cpu_idle();

    // Boot with no image: the whole store reads back as zero
    do_reset();
    wait_clear(1'b0);
    boot_pulse();
    for (int a = 0; a < 64; a++) cpu_read(6'(a), 16'h0000);
    cpu_idle();

    // Reset mid-LOAD after two words, then re-clear and boot
    do_reset();
    wait_clear(1'b0);
    load_word(16'h1111, 1'b0);
    load_word(16'h2222, 1'b0);
    check("ld_ready_mid_load", {31'h0, ld_ready}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_load_rst_ld_ready", {31'h0, ld_ready}, 32'h0);
    check("mid_load_rst_run", {31'h0, run}, 32'h0);
    check("mid_load_rst_mem", {16'h0, mem}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b0);
    boot_pulse();
    cpu_read(6'd8, 16'h0000);
    cpu_read(6'd9, 16'h0000);
    cpu_idle();
    cpu_idle();

    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
